// File: rtl/sdh_pkg.sv
// Shared definitions for the SDH frame-position counter: FSM states,
// STM-1 default geometry and just_act bit positions.
package sdh_pkg;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        RUN      = 2'd1,
        PEND_INC = 2'd2,
        PEND_DEC = 2'd3
    } sdh_state_e;

    localparam int unsigned STM1_MAXROW = 9;
    localparam int unsigned STM1_MAXCOL = 90;
    localparam int unsigned STM1_MAXSTS = 3;
    localparam int unsigned STM1_TOHCOL = 3;
    localparam int unsigned STM1_SOFCOL = 3;
    localparam int unsigned STM1_PTRROW = 3;

    localparam int unsigned JUST_POS = 0;
    localparam int unsigned JUST_NEG = 1;

endpackage

// File: rtl/sdh_pos_cnt_wrap.sv
// sdh_wrap_cnt: generic modulo-MAX counter with load, advance and carry-out.
// cnt_nxt exposes the next-state value so the parent can register flags
// for the same byte without an extra cycle of latency.
module sdh_wrap_cnt #(
    parameter int unsigned W   = 2,
    parameter int unsigned MAX = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         co
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         at_max;

    // next count: load wins over advance; wrap at MAX-1
    always_comb begin
        at_max = (cnt_q == W'(MAX - 1));
        cnt_d  = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = at_max ? '0 : cnt_q + W'(1);
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign cnt_nxt = cnt_d;
    assign co      = inc & at_max;

endmodule

// File: rtl/sdh_pos_cnt.sv
// sdh_pos_cnt: SDH frame-position counter (row/col/sts) with hunt/lock,
// TOH/payload flags and justification-window handling.
// Optional feature macro: SDH_SOF_CHECK_EN (rxsof position check, sof_err_cnt).
module sdh_pos_cnt
    import sdh_pkg::*;
#(
    parameter int unsigned RWID   = 4,
    parameter int unsigned CWID   = 7,
    parameter int unsigned SWID   = 2,
    parameter int unsigned MAXROW = STM1_MAXROW,
    parameter int unsigned MAXCOL = STM1_MAXCOL,
    parameter int unsigned MAXSTS = STM1_MAXSTS,
    parameter int unsigned TOHCOL = STM1_TOHCOL,
    parameter int unsigned SOFCOL = STM1_SOFCOL,
    parameter int unsigned PTRROW = STM1_PTRROW
) (
    input  logic            clk19,
    input  logic            rst_n,
    input  logic            en,
    input  logic            rxsof,
    input  logic            inc,
    input  logic            dec,
    output logic [RWID-1:0] row,
    output logic [CWID-1:0] col,
    output logic [SWID-1:0] sts,
    output logic            locked,
    output logic            oh,
    output logic            pld_vld,
    output logic            sof_out,
    output logic [1:0]      just_act,
    output logic            just_err,
    output logic            sof_err
`ifdef SDH_SOF_CHECK_EN
    ,
    output logic [7:0]      sof_err_cnt
`endif
);

    logic            ld;
    logic [RWID-1:0] row_q, row_d;
    logic [CWID-1:0] col_q, col_d;
    logic [SWID-1:0] sts_q, sts_d;
    logic            sts_co, col_co, row_co;

    sdh_state_e      state_q, state_d;
    logic            locked_q, locked_d;
    logic            oh_q, oh_d;
    logic            pld_q, pld_d;
    logic            sof_q, sof_d;
    logic [1:0]      just_act_q, just_act_d;
    logic            just_err_q, just_err_d;
    logic            row_end, win_done, win_pos, win_neg;

    assign ld = en & rxsof;

    sdh_wrap_cnt #(.W(SWID), .MAX(MAXSTS)) u_sts (
        .clk(clk19), .rst_n(rst_n), .inc(en), .load(ld), .load_val('0),
        .cnt(sts_q), .cnt_nxt(sts_d), .co(sts_co)
    );

    sdh_wrap_cnt #(.W(CWID), .MAX(MAXCOL)) u_col (
        .clk(clk19), .rst_n(rst_n), .inc(sts_co), .load(ld), .load_val(CWID'(SOFCOL)),
        .cnt(col_q), .cnt_nxt(col_d), .co(col_co)
    );

    sdh_wrap_cnt #(.W(RWID), .MAX(MAXROW)) u_row (
        .clk(clk19), .rst_n(rst_n), .inc(col_co), .load(ld), .load_val('0),
        .cnt(row_q), .cnt_nxt(row_d), .co(row_co)
    );

    // hunt/lock and justification-request FSM next state
    always_comb begin
        state_d    = state_q;
        just_err_d = 1'b0;
        row_end    = col_co && (row_q == RWID'(PTRROW));
        win_done   = (state_q == PEND_INC) ? just_act_q[JUST_POS] : just_act_q[JUST_NEG];
        if (en) begin
            if (state_q == HUNT) begin
                if (rxsof) state_d = RUN;
            end else if (state_q == RUN) begin
                if (inc && dec)   just_err_d = 1'b1;
                else if (inc)     state_d = PEND_INC;
                else if (dec)     state_d = PEND_DEC;
            end else begin
                if (inc || dec)   just_err_d = 1'b1;
                // a request that missed this frame's window stays pending
                if (row_end && win_done) state_d = RUN;
            end
        end
    end

    // byte flags from the next-state position so they line up with row/col/sts
    always_comb begin
        win_pos    = (row_d == RWID'(PTRROW)) && (col_d == CWID'(TOHCOL));
        win_neg    = (row_d == RWID'(PTRROW)) && (col_d == CWID'(TOHCOL - 1));
        locked_d   = (state_d != HUNT);
        oh_d       = (col_d < CWID'(TOHCOL));
        pld_d      = locked_d && !oh_d;
        sof_d      = (row_d == '0) && (col_d == '0) && (sts_d == '0);
        just_act_d = just_act_q;
        if (row_co && !ld) just_act_d = '0;
        if ((state_d == PEND_INC) && win_pos) begin
            pld_d                = 1'b0;
            just_act_d[JUST_POS] = 1'b1;
        end
        if ((state_d == PEND_DEC) && win_neg) begin
            pld_d                = 1'b1;
            just_act_d[JUST_NEG] = 1'b1;
        end
    end

    // FSM and output flag registers
    always_ff @(posedge clk19 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            locked_q   <= 1'b0;
            oh_q       <= 1'b0;
            pld_q      <= 1'b0;
            sof_q      <= 1'b0;
            just_act_q <= '0;
            just_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            locked_q   <= locked_d;
            oh_q       <= oh_d;
            pld_q      <= pld_d;
            sof_q      <= sof_d;
            just_act_q <= just_act_d;
            just_err_q <= just_err_d;
        end
    end

`ifdef SDH_SOF_CHECK_EN
    logic       sof_err_q, sof_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    // rxsof while locked must arrive on the byte just before (0,SOFCOL,0)
    always_comb begin
        sof_err_d = ld && (state_q != HUNT) &&
                    !((row_q == '0) && (col_q == CWID'(SOFCOL - 1)) &&
                      (sts_q == SWID'(MAXSTS - 1)));
        err_cnt_d = (sof_err_d && (err_cnt_q != '1)) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    // sof error pulse and saturating debug counter
    always_ff @(posedge clk19 or negedge rst_n) begin
        if (!rst_n) begin
            sof_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            sof_err_q <= sof_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign sof_err     = sof_err_q;
    assign sof_err_cnt = err_cnt_q;
`else
    assign sof_err = 1'b0;
`endif

    assign row      = row_q;
    assign col      = col_q;
    assign sts      = sts_q;
    assign locked   = locked_q;
    assign oh       = oh_q;
    assign pld_vld  = pld_q;
    assign sof_out  = sof_q;
    assign just_act = just_act_q;
    assign just_err = just_err_q;

endmodule

// File: tb/tb_sdh_pos_cnt.sv
// Scoreboard bench for sdh_pos_cnt: stimulus pushes the expected byte
// description for every en cycle; a negedge monitor pops and compares.
module tb_sdh_pos_cnt;

    localparam int NROW = 9;
    localparam int NCOL = 90;
    localparam int NSTS = 3;

    typedef struct packed {
        logic [3:0] row;
        logic [6:0] col;
        logic [1:0] sts;
        logic       locked;
        logic       oh;
        logic       pld;
        logic       sof;
        logic [1:0] just;
        logic       jerr;
        logic       serr;
    } rec_t;

    logic       clk19, rst_n, en, rxsof, inc, dec;
    logic [3:0] row;
    logic [6:0] col;
    logic [1:0] sts;
    logic       locked, oh, pld_vld, sof_out, just_err, sof_err;
    logic [1:0] just_act;
`ifdef SDH_SOF_CHECK_EN
    logic [7:0] sof_err_cnt;
`endif

    sdh_pos_cnt dut (
        .clk19(clk19), .rst_n(rst_n), .en(en), .rxsof(rxsof), .inc(inc), .dec(dec),
        .row(row), .col(col), .sts(sts), .locked(locked), .oh(oh),
        .pld_vld(pld_vld), .sof_out(sof_out), .just_act(just_act),
        .just_err(just_err), .sof_err(sof_err)
`ifdef SDH_SOF_CHECK_EN
        , .sof_err_cnt(sof_err_cnt)
`endif
    );

    int   tests = 0;
    int   fails = 0;
    rec_t exp_q[$];
    logic en_s;

    // reference position and expectation state
    int         m_row, m_col, m_sts;
    bit         m_locked;
    logic [1:0] m_just;
    int         exp_pend;   // 0 none, 1 inc pending, 2 dec pending

    initial clk19 = 1'b0;
    always #5 clk19 = ~clk19;

    always @(posedge clk19 or negedge rst_n) begin
        if (!rst_n) en_s <= 1'b0;
        else        en_s <= en;
    end

    // monitor: every en byte must match the next queued expectation
    always @(negedge clk19) begin : mon
        rec_t a, e;
        if (en_s) begin
            a = '{row, col, sts, locked, oh, pld_vld, sof_out, just_act, just_err, sof_err};
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL byte: DUT byte r%0d c%0d s%0d with no expectation queued", row, col, sts);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    fails++;
                    $display("FAIL byte: got r%0d c%0d s%0d lk%0b oh%0b pv%0b sof%0b ja%b je%0b se%0b, want r%0d c%0d s%0d lk%0b oh%0b pv%0b sof%0b ja%b je%0b se%0b",
                             a.row, a.col, a.sts, a.locked, a.oh, a.pld, a.sof, a.just, a.jerr, a.serr,
                             e.row, e.col, e.sts, e.locked, e.oh, e.pld, e.sof, e.just, e.jerr, e.serr);
                end
            end
        end
    end

    task automatic chk_reset(input string name);
        tests++;
        if ({row, col, sts, locked, oh, pld_vld, sof_out, just_act, just_err, sof_err} !== '0) begin
            fails++;
            $display("FAIL %s: got r%0d c%0d s%0d lk%0b oh%0b pv%0b sof%0b ja%b je%0b se%0b, want all 0",
                     name, row, col, sts, locked, oh, pld_vld, sof_out, just_act, just_err, sof_err);
        end
    endtask

    task automatic model_reset();
        m_row = 0; m_col = 0; m_sts = 0;
        m_locked = 0; m_just = 2'b00; exp_pend = 0;
    endtask

    // drive one cycle; on en bytes push the expected description of the next byte
    task automatic step(input bit e, input bit s, input bit i, input bit d,
                        input bit je, input bit se);
        rec_t r;
        bit   o, p, f;
        en = e; rxsof = s; inc = i; dec = d;
        if (e) begin
            if (m_row == 3 && m_col == NCOL-1 && m_sts == NSTS-1 && exp_pend != 0 &&
                m_just[exp_pend-1]) exp_pend = 0;
            if (s) begin
                m_row = 0; m_col = 3; m_sts = 0; m_locked = 1;
            end else begin
                m_sts++;
                if (m_sts == NSTS) begin
                    m_sts = 0; m_col++;
                    if (m_col == NCOL) begin
                        m_col = 0; m_row++;
                        if (m_row == NROW) m_row = 0;
                    end
                end
            end
            o = (m_col < 3);
            p = m_locked && !o;
            f = (m_row == 0 && m_col == 0 && m_sts == 0);
            if (f) m_just = 2'b00;
            if (exp_pend == 1 && m_row == 3 && m_col == 3) begin p = 0; m_just[0] = 1'b1; end
            if (exp_pend == 2 && m_row == 3 && m_col == 2) begin p = 1; m_just[1] = 1'b1; end
            r = '{4'(m_row), 7'(m_col), 2'(m_sts), m_locked, o, p, f, m_just, je, se};
            exp_q.push_back(r);
        end
        @(posedge clk19); #1;
    endtask

    task automatic run_to(input int r, input int c, input int s);
        int n;
        n = 0;
        while (!(m_row == r && m_col == c && m_sts == s)) begin
            if (n == 3000) begin
                tests++; fails++;
                $display("FAIL run_to: step budget expired before (%0d,%0d,%0d)", r, c, s);
                return;
            end
            step(1, 0, 0, 0, 0, 0);
            n++;
        end
    endtask

    localparam bit SERR_EXP =
`ifdef SDH_SOF_CHECK_EN
        1'b1;
`else
        1'b0;
`endif

    initial begin : stim
        int w;
        rst_n = 1'b0; en = 1'b0; rxsof = 1'b0; inc = 1'b0; dec = 1'b0;
        model_reset();
        repeat (3) @(posedge clk19);
        #1;
        chk_reset("reset_state");
        rst_n = 1'b1;
        @(posedge clk19); #1;

        // 1: requests in HUNT are silent, lock on rxsof, full frame to sof_out
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        run_to(0, 0, 0);

        // 2: en toggling over a full frame
        for (int k = 0; k < NROW*NCOL*NSTS; k++) begin
            step(1, 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end

        // 3: positive justification, then a normal frame
        run_to(1, 10, 0);
        exp_pend = 1;
        step(1, 0, 1, 0, 0, 0);
        run_to(0, 0, 0);
        run_to(8, 0, 0);
        run_to(0, 0, 0);

        // 4: negative justification, requests while pending and inc&dec in RUN
        run_to(1, 5, 0);
        exp_pend = 2;
        step(1, 0, 0, 1, 0, 0);
        run_to(2, 50, 1);
        step(1, 0, 1, 0, 1, 0);
        run_to(3, 5, 0);
        step(1, 0, 1, 1, 1, 0);
        run_to(5, 0, 0);
        step(1, 0, 1, 1, 1, 0);
        run_to(0, 0, 0);

        // 5: late inc leaves PEND_INC across the frame, reset mid-frame
        run_to(4, 10, 0);
        exp_pend = 1;
        step(1, 0, 1, 0, 0, 0);
        run_to(5, 40, 1);
        step(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_reset("reset_async");
        repeat (2) @(posedge clk19);
        #1;
        chk_reset("reset_held");
        rst_n = 1'b1;
        model_reset();
        step(1, 1, 0, 0, 0, 0);
        run_to(3, 6, 0);

        // 6: misplaced rxsof, then a correctly timed one
        run_to(4, 10, 2);
        step(1, 1, 0, 0, 0, SERR_EXP);
`ifdef SDH_SOF_CHECK_EN
        tests++;
        if (sof_err_cnt !== 8'd1) begin
            fails++;
            $display("FAIL sof_err_cnt_first: got %0d want 1", sof_err_cnt);
        end
`endif
        run_to(0, 2, 2);
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
`ifdef SDH_SOF_CHECK_EN
        tests++;
        if (sof_err_cnt !== 8'd1) begin
            fails++;
            $display("FAIL sof_err_cnt_hold: got %0d want 1", sof_err_cnt);
        end
`endif
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        w = 0;
        while (exp_q.size() != 0 && w < 10) begin
            @(posedge clk19); #1;
            w++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
